// File: rtl/multicore_pkg.sv
// Shared core-wide types and constants used by the writeback port arbiter.
package multicore_pkg;

  localparam int NUM_REGS                = 32;
  localparam int DATA_SIZE               = 32;
  localparam int WB_STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [0:0] {
    S_PIPE = 1'b0,
    S_LL   = 1'b1
  } wb_arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_scoreboard.sv
// Busy-register vector: set on long-latency issue, cleared on long-latency writeback.
// Register 0 is never marked busy; a same-cycle set and clear of one register leaves it set.
module wb_scoreboard
  import multicore_pkg::*;
#(
  parameter int NUM_REGS = multicore_pkg::NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                i_aclk,
  input  logic                i_areset_n,
  input  logic                i_set,
  input  logic [AW-1:0]       i_set_addr,
  input  logic                i_clr,
  input  logic [AW-1:0]       i_clr_addr,
  input  logic [AW-1:0]       i_rd0_addr,
  output logic                o_rd0_busy,
  input  logic [AW-1:0]       i_rd1_addr,
  output logic                o_rd1_busy,
  output logic [NUM_REGS-1:0] o_busy_vec
);

  logic [NUM_REGS-1:0] r_busy;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_set && (i_set_addr == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (i_clr && (i_clr_addr == AW'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Bit 0 is held low, so x0 reads as not busy without an extra compare.
  assign o_rd0_busy = r_busy[i_rd0_addr];
  assign o_rd1_busy = r_busy[i_rd1_addr];
  assign o_busy_vec = r_busy;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs long-latency results, with starvation guard.
// Optional build macro WB_PERF_EN adds saturating stall / forced-grant counters.
module wb_port_arbiter
  import multicore_pkg::*;
#(
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DEFAULT,
  parameter int NUM_REGS     = multicore_pkg::NUM_REGS,
  parameter int DATA_SIZE    = multicore_pkg::DATA_SIZE,
  parameter int AW           = $clog2(NUM_REGS)
) (
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_pipe_valid,
  input  logic [AW-1:0]        i_pipe_rdest,
  input  logic [DATA_SIZE-1:0] i_pipe_data,
  output logic                 o_pipe_stall,
  input  logic                 i_issue_valid,
  input  logic [AW-1:0]        i_issue_rdest,
  input  logic                 i_ll_valid,
  input  logic [AW-1:0]        i_ll_rdest,
  input  logic [DATA_SIZE-1:0] i_ll_data,
  output logic                 o_ll_ready,
  output logic                 o_rf_we,
  output logic [AW-1:0]        o_rf_waddr,
  output logic [DATA_SIZE-1:0] o_rf_wdata,
  input  logic [AW-1:0]        i_chk_rs1,
  input  logic [AW-1:0]        i_chk_rs2,
  output logic                 o_rs1_busy,
  output logic                 o_rs2_busy,
  output logic [31:0]          o_perf_pipe_stalls,
  output logic [31:0]          o_perf_ll_forced,
  output wb_arb_state_e        o_dbg_state,
  output logic [NUM_REGS-1:0]  o_dbg_busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Handshake: a request transfers in the cycle its valid is high and its grant is high;
  // the requester holds rdest/data stable until that cycle.
  wb_arb_state_e        r_state;
  logic [3:0]           r_starve;
  logic                 w_grant_pipe;
  logic                 w_grant_ll;
  logic [NUM_REGS-1:0]  w_busy;

  assign w_grant_pipe = (r_state == S_PIPE) && i_pipe_valid;
  assign w_grant_ll   = i_ll_valid && ((r_state == S_LL) || !i_pipe_valid);
  assign o_pipe_stall = i_pipe_valid && !w_grant_pipe;
  assign o_ll_ready   = w_grant_ll;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_state    <= S_PIPE;
      r_starve   <= '0;
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else begin
      o_rf_we <= (w_grant_pipe && (i_pipe_rdest != '0)) ||
                 (w_grant_ll && (i_ll_rdest != '0));
      if (w_grant_pipe) begin
        o_rf_waddr <= i_pipe_rdest;
        o_rf_wdata <= i_pipe_data;
      end else if (w_grant_ll) begin
        o_rf_waddr <= i_ll_rdest;
        o_rf_wdata <= i_ll_data;
      end
      case (r_state)
        S_PIPE: begin
          if (i_ll_valid && i_pipe_valid) begin
            r_starve <= r_starve + 4'd1;
            // Force the LL side next cycle once it has lost STARVE_LIMIT times in a row.
            if (r_starve + 4'd1 == LIMIT) r_state <= S_LL;
          end else begin
            r_starve <= '0;
          end
        end
        S_LL: begin
          r_starve <= '0;
          r_state  <= S_PIPE;
        end
        default: begin
          r_starve <= '0;
          r_state  <= S_PIPE;
        end
      endcase
    end
  end

  wb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_set      (i_issue_valid),
    .i_set_addr (i_issue_rdest),
    .i_clr      (w_grant_ll),
    .i_clr_addr (i_ll_rdest),
    .i_rd0_addr (i_chk_rs1),
    .o_rd0_busy (o_rs1_busy),
    .i_rd1_addr (i_chk_rs2),
    .o_rd1_busy (o_rs2_busy),
    .o_busy_vec (w_busy)
  );

  assign o_dbg_state = r_state;
  assign o_dbg_busy  = w_busy;

`ifdef WB_PERF_EN
  logic [31:0] r_perf_stalls;
  logic [31:0] r_perf_forced;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_perf_stalls <= '0;
      r_perf_forced <= '0;
    end else begin
      if (o_pipe_stall && (r_perf_stalls != '1)) r_perf_stalls <= r_perf_stalls + 32'd1;
      if ((r_state == S_LL) && w_grant_ll && (r_perf_forced != '1))
        r_perf_forced <= r_perf_forced + 32'd1;
    end
  end

  assign o_perf_pipe_stalls = r_perf_stalls;
  assign o_perf_ll_forced   = r_perf_forced;
`else
  assign o_perf_pipe_stalls = '0;
  assign o_perf_ll_forced   = '0;
`endif

  // A same-cycle LL writeback to the issued register frees it first, so that case is legal.
  a_issue_busy: assert property (@(posedge i_aclk) disable iff (!i_areset_n)
    !(i_issue_valid && (i_issue_rdest != '0) && w_busy[i_issue_rdest] &&
      !(w_grant_ll && (i_ll_rdest == i_issue_rdest))));
  a_pipe_busy: assert property (@(posedge i_aclk) disable iff (!i_areset_n)
    !(w_grant_pipe && (i_pipe_rdest != '0) && w_busy[i_pipe_rdest]));
  a_ll_not_busy: assert property (@(posedge i_aclk) disable iff (!i_areset_n)
    !(i_ll_valid && (i_ll_rdest != '0) && !w_busy[i_ll_rdest]));

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port.
- Shares it between the in-order pipeline writeback result and a long-latency unit (MUL/DIV, miss-returned loads) that completes out of band.
- Holds a busy-register scoreboard so decode can stall on outstanding long-latency destinations.
- Sits between the writeback stage / long-latency unit and the register file. Regfile write is registered here.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a pending long-latency result may lose arbitration before it is force-granted (1..15).
- NUM_REGS, multicore_pkg::NUM_REGS, architectural register count; x0 hardwired zero.
- DATA_SIZE, multicore_pkg::DATA_SIZE, register data width.

Ports:
- i_aclk  in  1  system clock
- i_areset_n  in  1  asynchronous active-low reset
- i_pipe_valid  in  1  pipeline writeback result valid (already gated by regwrite)
- i_pipe_rdest  in  $clog2(NUM_REGS)  pipeline destination
- i_pipe_data  in  DATA_SIZE  pipeline result
- o_pipe_stall  out  1  pipeline result not accepted this cycle; hold stage
- i_issue_valid  in  1  long-latency op issued this cycle
- i_issue_rdest  in  $clog2(NUM_REGS)  its destination, marked busy
- i_ll_valid  in  1  long-latency result valid
- i_ll_rdest  in  $clog2(NUM_REGS)  long-latency destination
- i_ll_data  in  DATA_SIZE  long-latency result
- o_ll_ready  out  1  long-latency result accepted this cycle
- o_rf_we  out  1  regfile write enable
- o_rf_waddr  out  $clog2(NUM_REGS)  regfile write address
- o_rf_wdata  out  DATA_SIZE  regfile write data
- i_chk_rs1, i_chk_rs2  in  $clog2(NUM_REGS) each  decode source registers
- o_rs1_busy, o_rs2_busy  out  1 each  source has an outstanding long-latency write

Behaviour:
- Reset is i_areset_n, asynchronous, active-low; clock is i_aclk.
- Reset values: o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, busy vector all 0, starve counter 0, FSM=S_PIPE.
- Handshake: a request transfers when valid && accepted in the same cycle. The requester holds rdest/data stable while not accepted.
- o_pipe_stall = i_pipe_valid && !grant_pipe.
- o_ll_ready = grant_ll.
- Both are combinational from the current inputs and state.
- FSM S_PIPE, arbitration:
  - Pipeline valid: pipeline granted. If i_ll_valid is also asserted, the starve counter increments.
  - Pipeline idle: the long-latency result is granted and the counter clears.
  - Transition to S_LL when the counter reaches STARVE_LIMIT with i_ll_valid still asserted.
- FSM S_LL:
  - Long-latency result granted unconditionally; pipeline stalled.
  - Counter clears; return to S_PIPE next cycle.
  - If i_ll_valid drops, grant nothing from the LL side, return to S_PIPE, counter clears.
- Starve counter clears whenever i_ll_valid=0.
- Latency: a granted request appears on o_rf_* at the next clock edge (1 cycle). o_rf_we pulses one cycle per grant.
- x0: a granted request with rdest=0 is accepted (handshake completes) but o_rf_we stays 0.
- Scoreboard:
  - i_issue_valid sets busy[i_issue_rdest] at the edge. rdest=0 is ignored.
  - A granted LL transfer clears busy[i_ll_rdest] at the edge.
  - Same-cycle set and clear of the same register: set wins.
- o_rsN_busy is combinational: busy[i_chk_rsN] OR (granted LL write to that register this cycle is NOT counted, i.e. busy until the regfile write is visible). Register 0 never reports busy.
- Illegal conditions (simulation assertions only):
  - issue to an already-busy register;
  - pipeline write to a busy register;
  - LL result to a non-busy register.
- Reset mid-operation: all pending state is discarded and the busy vector is cleared. Requesters re-present after reset.

Optional Feature:
- WB_PERF_EN defined: adds o_perf_pipe_stalls and o_perf_ll_forced (32-bit each).
  - o_perf_pipe_stalls counts cycles with o_pipe_stall=1.
  - o_perf_ll_forced counts S_LL grants.
  - Both are saturating, reset to 0.
- WB_PERF_EN undefined: both ports are still present, driven constant 0, and no counter logic is built.

Decomposition:
- multicore_pkg gains the wb_arb_state_e enum {S_PIPE, S_LL} and the constant WB_STARVE_LIMIT_DEFAULT=4.
- One natural sub-module: wb_scoreboard (busy vector, set/clear, two combinational read ports).

Test Plan:
- Pipeline-only: i_pipe_valid with rdest=5, data=0x1234 -> o_rf_we=1, waddr=5, wdata=0x1234 next cycle; o_pipe_stall=0.
- LL-only: issue rd=7, then ll_valid with data=0xBEEF -> o_rs1_busy=1 for rs1=7 until the grant; write one cycle later; busy clears.
- Starvation, STARVE_LIMIT=4: pipe_valid and ll_valid held continuously -> 4 pipeline grants, then one LL grant with o_pipe_stall=1 for exactly that cycle.
- x0: pipe write rdest=0 -> no stall, o_rf_we=0; issue rd=0 -> busy never set.
- Same-cycle issue rd=3 while the LL result for rd=3 is granted -> busy[3]=1 afterwards.
- Assert i_areset_n low while in S_LL with busy bits set -> all outputs 0, busy vector clear, FSM=S_PIPE; WB_PERF_EN counters read 0.
